// File: rtl/data_sram_bridge.sv
// Memory-stage bridge: turns the core's single-cycle data request into an
// SRAM-like address/data handshake, generates the memory stall and latches load data.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IDLE      | no transaction; a cpu_req issues the address phase at once
// WAIT_ADDR | address phase presented, waiting for data_addr_ok
// WAIT_DATA | address accepted, waiting for data_data_ok
// DONE      | data captured; held here while the pipeline is frozen
module data_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [DATA_W/8-1:0]   cpu_wen,
  input  logic [1:0]            cpu_size,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  cpu_longest_stall,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [DATA_W-1:0]     data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_W-1:0]     data_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                idle_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        // A simultaneous data_ok here is ignored; only the address phase is taken.
        if (cpu_req) state_d = data_addr_ok ? WAIT_DATA : WAIT_ADDR;
      end
      WAIT_ADDR: begin
        if (data_addr_ok) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (data_data_ok) begin
          state_d = DONE;
          rdata_d = data_rdata;
        end
      end
      DONE: begin
        if (!cpu_longest_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign idle_req  = (state_q == IDLE) && cpu_req;
  assign data_req  = idle_req || (state_q == WAIT_ADDR);
  assign cpu_stall = idle_req || (state_q == WAIT_ADDR) || (state_q == WAIT_DATA);
  assign cpu_rdata = rdata_q;

  // Bus fields follow the core directly; the core holds them while stalled.
  assign data_wr    = |cpu_wen;
  assign data_size  = cpu_size;
  assign data_wdata = cpu_wdata;

  // kseg0/kseg1 (top bits 100/101) are unmapped: strip the top three bits.
  always_comb begin
    data_addr = cpu_addr;
    if (cpu_addr[ADDR_W-1 -: 2] == 2'b10) data_addr[ADDR_W-1 -: 3] = 3'b000;
  end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Scoreboard bench for data_sram_bridge: directed accesses push expected bus
// phases and load results; a monitor pops and compares them as the DUT presents them.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [3:0]  cpu_wen;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_longest_stall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } bus_exp_t;

  bus_exp_t    exp_bus[$];
  logic [31:0] exp_rd[$];

  data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_req           (cpu_req),
    .cpu_wen           (cpu_wen),
    .cpu_size          (cpu_size),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_rdata         (cpu_rdata),
    .cpu_stall         (cpu_stall),
    .cpu_longest_stall (cpu_longest_stall),
    .data_req          (data_req),
    .data_wr           (data_wr),
    .data_size         (data_size),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_addr_ok      (data_addr_ok),
    .data_data_ok      (data_data_ok),
    .data_rdata        (data_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: address handshakes and load completions (stall falling) pop the queues.
  initial begin
    logic     prev_stall;
    bus_exp_t e;
    logic [31:0] r;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && data_req && data_addr_ok) begin
        if (exp_bus.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL bus_unexpected: got handshake at %h expected none", data_addr);
        end else begin
          e = exp_bus.pop_front();
          chk("bus_addr",  data_addr,          e.addr);
          chk("bus_wr",    32'(data_wr),       32'(e.wr));
          chk("bus_size",  32'(data_size),     32'(e.size));
          chk("bus_wdata", data_wdata,         e.wdata);
        end
      end
      if (rst && prev_stall && !cpu_stall) begin
        if (exp_rd.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rdata_unexpected: got completion %h expected none", cpu_rdata);
        end else begin
          r = exp_rd.pop_front();
          chk("cpu_rdata", cpu_rdata, r);
        end
      end
      prev_stall = rst & cpu_stall;
    end
  end

  // One complete access, called at posedge+1 with the bridge in IDLE.
  task automatic access(input string nm, input logic [31:0] addr, input logic [3:0] wen,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input logic [31:0] exp_addr, input int addr_dly, input int data_dly,
                        input logic [31:0] rd, input int ls, input bit drop, input bit both);
    int fin, sn, rn;
    fin = addr_dly + data_dly + 2;
    sn = 0; rn = 0;
    exp_bus.push_back('{exp_addr, |wen, size, wdata});
    exp_rd.push_back(rd);
    cpu_addr = addr; cpu_wen = wen; cpu_size = size; cpu_wdata = wdata;
    for (int c = 0; c <= fin; c++) begin
      cpu_req           = (c == 0) || (!drop && c < fin);
      data_addr_ok      = (c == addr_dly);
      data_data_ok      = (c == addr_dly + 1 + data_dly) || (both && c == addr_dly);
      data_rdata        = (c == addr_dly + 1 + data_dly) ? rd : 32'h0BAD0BAD;
      cpu_longest_stall = (c == fin) && (ls > 0);
      @(negedge clk);
      sn += int'(cpu_stall);
      rn += int'(data_req);
      if (c == fin) chk({nm, "_done_stall"}, 32'(cpu_stall), 32'd0);
      @(posedge clk); #1;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0; cpu_req = 1'b0;
    for (int k = 1; k <= ls; k++) begin
      cpu_longest_stall = (k < ls);
      @(negedge clk);
      chk({nm, "_hold_req"},   32'(data_req),  32'd0);
      chk({nm, "_hold_stall"}, 32'(cpu_stall), 32'd0);
      chk({nm, "_hold_rdata"}, cpu_rdata,      rd);
      @(posedge clk); #1;
    end
    cpu_longest_stall = 1'b0;
    chk({nm, "_stall_cycles"}, 32'(sn), 32'(fin));
    chk({nm, "_req_cycles"},   32'(rn), drop ? 32'(addr_dly + 1) : 32'(addr_dly + 1));
  endtask

  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_wen = '0; cpu_size = 2'd2; cpu_addr = '0;
    cpu_wdata = '0; cpu_longest_stall = 1'b0; data_addr_ok = 1'b0;
    data_data_ok = 1'b0; data_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_req",   32'(data_req),  32'd0);
    chk("rst_rdata", cpu_rdata,      32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    access("ld_kseg0", 32'h8000_1000, 4'b0000, 2'd2, 32'h0,
           32'h0000_1000, 0, 0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    access("sb_kseg1", 32'hBFC0_0002, 4'b0100, 2'd0, 32'h00AB_0000,
           32'h1FC0_0002, 3, 0, 32'h1234_5678, 0, 1'b0, 1'b0);
    access("ld_freeze", 32'h9000_0010, 4'b0000, 2'd2, 32'h0,
           32'h1000_0010, 1, 2, 32'hCAFE_F00D, 4, 1'b0, 1'b0);
    access("ld_b2b0", 32'h0040_0000, 4'b0000, 2'd2, 32'h0,
           32'h0040_0000, 0, 1, 32'h1111_1111, 0, 1'b0, 1'b0);
    access("ld_b2b1", 32'h0040_0004, 4'b0000, 2'd2, 32'h0,
           32'h0040_0004, 0, 0, 32'h2222_2222, 0, 1'b0, 1'b1);
    access("ld_kseg2", 32'hC000_0008, 4'b0000, 2'd1, 32'h0,
           32'hC000_0008, 0, 0, 32'h3333_4444, 0, 1'b0, 1'b0);

    // Reset in WAIT_DATA: the address phase completes, data never does.
    exp_bus.push_back('{32'h0000_0200, 1'b0, 2'd2, 32'h0});
    cpu_addr = 32'h0000_0200; cpu_wen = 4'b0000; cpu_size = 2'd2; cpu_req = 1'b1;
    data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    @(negedge clk);
    chk("wd_stall", 32'(cpu_stall), 32'd1);
    @(posedge clk); #1;
    #1 rst = 1'b0; cpu_req = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(cpu_stall), 32'd0);
    chk("mid_rst_req",   32'(data_req),  32'd0);
    chk("mid_rst_rdata", cpu_rdata,      32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    access("ld_after_rst", 32'h0000_0100, 4'b0000, 2'd2, 32'h0,
           32'h0000_0100, 0, 0, 32'h5A5A_A5A5, 0, 1'b0, 1'b0);

    access("sw_flush", 32'hA000_0020, 4'b1111, 2'd2, 32'h7654_3210,
           32'h0000_0020, 2, 1, 32'h0F0F_0F0F, 0, 1'b1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("flush_idle_req", 32'(data_req), 32'd0);
    end

    @(posedge clk); #1;
    chk("bus_queue_empty",   32'(exp_bus.size()), 32'd0);
    chk("rdata_queue_empty", 32'(exp_rd.size()),  32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_sram_bridge.md
Name: data_sram_bridge

Overview:
- Sits directly downstream of the core's memory-stage data port.
- Converts the core's single-cycle data request (enable, byte write-enables, address, write data) into a split address/data handshake on an SRAM-like bus with variable latency.
- Generates the memory-stage stall back into the pipeline's hazard logic.
- Latches read data so a result is never lost or re-requested while the pipeline is frozen by another stall source.

Parameters:
- ADDR_W, 32, address width on the core and bus sides
- DATA_W, 32, data width (byte lanes = DATA_W/8)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-low
- cpu_req  input  1  memory-stage access request (load or store)
- cpu_wen  input  4  byte write enables; nonzero means store
- cpu_size  input  2  access size: 0 byte, 1 half, 2 word
- cpu_addr  input  32  virtual byte address (aluout of memory stage)
- cpu_wdata  input  32  store data, already lane-aligned
- cpu_rdata  output  32  load data returned to the core
- cpu_stall  output  1  memory-stage stall request to the hazard unit
- cpu_longest_stall  input  1  global pipeline freeze from any other source
- data_req  output  1  bus request valid
- data_wr  output  1  1 = write, 0 = read
- data_size  output  2  bus access size
- data_addr  output  32  physical address
- data_wdata  output  32  bus write data
- data_addr_ok  input  1  slave accepted the address phase
- data_data_ok  input  1  slave completed the data phase
- data_rdata  input  32  bus read data, valid when data_data_ok

Behaviour:
- States: IDLE, WAIT_ADDR, WAIT_DATA, DONE.
- Reset (rst low, asynchronous):
  - state <= IDLE; rdata_r <= 0.
  - Outputs: cpu_rdata = 0, cpu_stall = 0, data_req = 0.
- data_req (combinational) = (IDLE & cpu_req) | WAIT_ADDR.
- Bus fields are driven combinationally from the cpu inputs. The core holds those inputs stable while cpu_stall is high.
  - data_wr = |cpu_wen
  - data_size = cpu_size
  - data_wdata = cpu_wdata
- Address map for data_addr:
  - cpu_addr[31:29] = 3'b100 or 3'b101 (kseg0/kseg1): top three bits cleared.
  - All other addresses pass unchanged.
- Transitions:
  - IDLE, cpu_req & data_addr_ok -> WAIT_DATA.
  - IDLE, cpu_req & !data_addr_ok -> WAIT_ADDR.
  - IDLE, no cpu_req -> stay IDLE.
  - WAIT_ADDR, data_addr_ok -> WAIT_DATA; otherwise hold with data_req high.
  - WAIT_DATA, data_data_ok -> DONE, and rdata_r <= data_rdata (captured for writes too; the core ignores it).
  - DONE, !cpu_longest_stall -> IDLE.
  - DONE, cpu_longest_stall -> stay DONE. No new data_req is issued and rdata_r is held.
- cpu_stall = (IDLE & cpu_req) | WAIT_ADDR | WAIT_DATA. It is 0 in DONE and in IDLE without a request.
- Latency: load data appears at cpu_rdata one cycle after data_data_ok, and cpu_stall falls in that same cycle. Minimum access is 2 stall cycles (addr_ok in the IDLE cycle, data_ok the next cycle).
- cpu_rdata = rdata_r at all times.
- One outstanding transaction only. data_addr_ok is ignored outside IDLE/WAIT_ADDR; data_data_ok is ignored outside WAIT_DATA.
- data_addr_ok and data_data_ok in the same IDLE cycle: only addr_ok is taken. The bridge moves to WAIT_DATA and waits for a subsequent data_ok.
- cpu_req dropping while in WAIT_ADDR or WAIT_DATA (e.g. pipeline flush): the transaction still completes to DONE. It is never abandoned mid-bus-phase.
- Reset asserted mid-transaction: returns to IDLE immediately. After reset the bench/slave must not deliver the stale data_ok; behaviour on one is not defined.
- Unaligned access checks belong to the exception unit, not this block. Addresses pass through unmodified apart from the address map.

Test Plan:
- Word load to 0x80001000, addr_ok in the request cycle, data_ok next cycle with 0xDEADBEEF:
  - data_addr = 0x00001000, data_wr = 0, size 2.
  - cpu_stall high exactly 2 cycles; cpu_rdata = 0xDEADBEEF in the following cycle.
- Byte store, cpu_wen = 4'b0100, address 0xBFC00002, wdata 0x00AB0000, addr_ok delayed 3 cycles, data_ok 1 cycle later:
  - data_req held 4 cycles; data_addr = 0x1FC00002; data_wr = 1.
  - cpu_stall high 5 cycles.
- Load completing while cpu_longest_stall = 1 for 4 extra cycles:
  - State stays DONE; no second data_req.
  - cpu_rdata holds the captured value throughout; returns to IDLE the cycle after longest_stall falls.
- Back-to-back loads to 0x00400000 and 0x00400004:
  - Address unchanged (useg).
  - Exactly two bus address handshakes; each rdata delivered in order.
- Reset pulsed low during WAIT_DATA:
  - cpu_stall and data_req are 0 immediately; cpu_rdata = 0; state IDLE.
  - A fresh request afterwards completes normally.
- cpu_req deasserted while in WAIT_ADDR:
  - data_req stays high until addr_ok; the transaction finishes to DONE, then IDLE with no further requests.
